// File: rtl/clock_pkg.sv
// Shared types and constants for the 12-hour clock set-mode controller:
// FSM state encoding, display field codes and edit-register widths.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HR   = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_SEC  = 2'd3;

    localparam int HR_W       = 4;
    localparam int MS_W       = 6;
    localparam int HR_MOD_DEF = 12;
    localparam int MS_MOD_DEF = 60;

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            SET_HR:  field_of = FLD_HR;
            SET_MIN: field_of = FLD_MIN;
            SET_SEC: field_of = FLD_SEC;
            default: field_of = FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button. History resets to 1 so a
// button already held when reset releases does not produce an edge.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = btn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = btn & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// 1 Hz advance generator plus button-driven set-mode FSM for the clock counter.
// Optional display blink in set mode is built when BLINK_EN is defined.
import clock_pkg::*;

module clock_set_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int HR_MOD   = HR_MOD_DEF,
    parameter int MS_MOD   = MS_MOD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [3:0]  cur_hours,
    input  logic [5:0]  cur_mins,
    input  logic [5:0]  cur_secs,
    output logic        tick_en,
    output logic        load,
    output logic [3:0]  load_hours,
    output logic [5:0]  load_mins,
    output logic [5:0]  load_secs,
    output logic        setting,
    output logic [1:0]  field,
    output logic        blink
);

    localparam int              CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_MOD - 1);
    localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(MS_MOD - 1);

    logic mode_edge;
    logic inc_edge;

    btn_edge u_mode_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_mode),
        .rise (mode_edge)
    );

    btn_edge u_inc_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_inc),
        .rise (inc_edge)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic              load_q, load_d;
    logic              setting_q, setting_d;
    logic [1:0]        field_q, field_d;
    logic [HR_W-1:0]   hr_q, hr_d;
    logic [MS_W-1:0]   min_q, min_d;
    logic [MS_W-1:0]   sec_q, sec_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        load_d  = 1'b0;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;

        case (state_q)
            RUN: begin
                // Hold the prescaler through the load cycle so the first
                // tick after leaving set mode lands TICK_DIV+1 cycles later.
                if (load_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (mode_edge) begin
                    hr_d    = cur_hours;
                    min_d   = cur_mins;
                    sec_d   = cur_secs;
                    state_d = SET_HR;
                end
            end
            SET_HR: begin
                cnt_d = '0;
                if (mode_edge) begin
                    state_d = SET_MIN;
                end else if (inc_edge) begin
                    hr_d = (hr_q >= HR_MAX) ? '0 : hr_q + HR_W'(1);
                end
            end
            SET_MIN: begin
                cnt_d = '0;
                if (mode_edge) begin
                    state_d = SET_SEC;
                end else if (inc_edge) begin
                    min_d = (min_q >= MS_MAX) ? '0 : min_q + MS_W'(1);
                end
            end
            SET_SEC: begin
                cnt_d = '0;
                if (mode_edge) begin
                    state_d = RUN;
                    load_d  = 1'b1;
                end else if (inc_edge) begin
                    sec_d = (sec_q >= MS_MAX) ? '0 : sec_q + MS_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        setting_d = (state_d != RUN);
        field_d   = field_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            load_q    <= 1'b0;
            setting_q <= 1'b0;
            field_q   <= FLD_NONE;
            hr_q      <= '0;
            min_q     <= '0;
            sec_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            load_q    <= load_d;
            setting_q <= setting_d;
            field_q   <= field_d;
            hr_q      <= hr_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
        end
    end

    assign tick_en    = tick_q;
    assign load       = load_q;
    assign load_hours = hr_q;
    assign load_mins  = min_q;
    assign load_secs  = sec_q;
    assign setting    = setting_q;
    assign field      = field_q;

`ifdef BLINK_EN
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(TICK_DIV / 2 - 1);

    logic [CNT_W-1:0] half_q, half_d;
    logic             blink_q, blink_d;

    always_comb begin
        half_d  = half_q;
        blink_d = blink_q;
        if (state_d == RUN) begin
            half_d  = '0;
            blink_d = 1'b0;
        end else if (mode_edge || inc_edge) begin
            // Restart the phase so the digit being edited is shown solid.
            half_d  = '0;
            blink_d = 1'b0;
        end else if (half_q == HALF_MAX) begin
            half_d  = '0;
            blink_d = ~blink_q;
        end else begin
            half_d = half_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            half_q  <= half_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Table-driven bench for clock_set_ctrl with TICK_DIV=4: each record holds
// one cycle of inputs and the outputs expected just after that clock edge.
module tb_clock_set_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DC       = 2;   // tick expectation "don't care"

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hours;
    logic [5:0] cur_mins;
    logic [5:0] cur_secs;
    logic       tick_en;
    logic       load;
    logic [3:0] load_hours;
    logic [5:0] load_mins;
    logic [5:0] load_secs;
    logic       setting;
    logic [1:0] field;
    logic       blink;

    clock_set_ctrl #(.TICK_DIV(TICK_DIV), .HR_MOD(12), .MS_MOD(60)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hours  (cur_hours),
        .cur_mins   (cur_mins),
        .cur_secs   (cur_secs),
        .tick_en    (tick_en),
        .load       (load),
        .load_hours (load_hours),
        .load_mins  (load_mins),
        .load_secs  (load_secs),
        .setting    (setting),
        .field      (field),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst, mode, inc, ch, cm, cs;
        int e_set, e_fld, e_load, e_h, e_m, e_s, e_tick;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ch_cur = 0, cm_cur = 0, cs_cur = 0;

    task automatic add(input int r, input int m, input int i,
                       input int es, input int ef, input int el,
                       input int eh, input int em, input int esec, input int et);
        vec_t v;
        v.rst = r; v.mode = m; v.inc = i;
        v.ch = ch_cur; v.cm = cm_cur; v.cs = cs_cur;
        v.e_set = es; v.e_fld = ef; v.e_load = el;
        v.e_h = eh; v.e_m = em; v.e_s = esec; v.e_tick = et;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", nm, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        cur_hours = '0; cur_mins = '0; cur_secs = '0;

        // Reset, then free run: tick every 4th cycle after release.
        add(1,0,0, 0,0,0, 0,0,0, 0);
        add(1,0,0, 0,0,0, 0,0,0, 0);
        for (int i = 1; i <= 20; i++) add(0,0,0, 0,0,0, 0,0,0, (i % 4 == 0) ? 1 : 0);

        // Full edit from 3:15:42 -> load 5:16:42, next tick 5 cycles after load.
        ch_cur = 3; cm_cur = 15; cs_cur = 42;
        add(0,1,0, 1,1,0, 3,15,42, 0);
        add(0,0,0, 1,1,0, 3,15,42, 0);
        add(0,0,1, 1,1,0, 4,15,42, 0);
        add(0,0,0, 1,1,0, 4,15,42, 0);
        add(0,0,1, 1,1,0, 5,15,42, 0);
        add(0,0,0, 1,1,0, 5,15,42, 0);
        add(0,1,0, 1,2,0, 5,15,42, 0);
        add(0,0,0, 1,2,0, 5,15,42, 0);
        add(0,0,1, 1,2,0, 5,16,42, 0);
        add(0,0,0, 1,2,0, 5,16,42, 0);
        add(0,1,0, 1,3,0, 5,16,42, 0);
        add(0,0,0, 1,3,0, 5,16,42, 0);
        add(0,1,0, 0,0,1, 5,16,42, 0);
        for (int k = 1; k <= 6; k++) add(0,0,0, 0,0,0, 5,16,42, (k == 5) ? 1 : 0);

        // Wrap at 11 and 59, simultaneous edges, held mode button.
        ch_cur = 11; cm_cur = 59; cs_cur = 59;
        add(0,1,0, 1,1,0, 11,59,59, 0);
        add(0,0,0, 1,1,0, 11,59,59, 0);
        add(0,0,1, 1,1,0, 0,59,59, 0);
        add(0,0,0, 1,1,0, 0,59,59, 0);
        add(0,1,0, 1,2,0, 0,59,59, 0);
        add(0,0,0, 1,2,0, 0,59,59, 0);
        add(0,0,1, 1,2,0, 0,0,59, 0);
        add(0,0,0, 1,2,0, 0,0,59, 0);
        add(0,0,1, 1,2,0, 0,1,59, 0);
        add(0,0,0, 1,2,0, 0,1,59, 0);
        add(0,1,1, 1,3,0, 0,1,59, 0);
        add(0,0,0, 1,3,0, 0,1,59, 0);
        add(0,1,0, 0,0,1, 0,1,59, 0);
        for (int k = 0; k <= 8; k++) add(0,1,0, 0,0,0, 0,1,59, (k == 4 || k == 8) ? 1 : 0);
        add(0,0,0, 0,0,0, 0,1,59, 0);

        // Out-of-range captured values wrap to 0 on the first increment.
        ch_cur = 14; cm_cur = 62; cs_cur = 63;
        add(0,1,0, 1,1,0, 14,62,63, 0);
        add(0,0,0, 1,1,0, 14,62,63, 0);
        add(0,0,1, 1,1,0, 0,62,63, 0);
        add(0,1,0, 1,2,0, 0,62,63, 0);
        add(0,0,1, 1,2,0, 0,0,63, 0);
        add(0,1,0, 1,3,0, 0,0,63, 0);
        add(0,0,1, 1,3,0, 0,0,0, 0);
        add(0,0,0, 1,3,0, 0,0,0, 0);
        add(0,1,0, 0,0,1, 0,0,0, 0);
        add(0,0,0, 0,0,0, 0,0,0, 0);

        // Reset in SET_SEC with mode held through reset release.
        ch_cur = 7; cm_cur = 8; cs_cur = 9;
        add(0,1,0, 1,1,0, 7,8,9, 0);
        add(0,0,0, 1,1,0, 7,8,9, 0);
        add(0,1,0, 1,2,0, 7,8,9, 0);
        add(0,0,0, 1,2,0, 7,8,9, 0);
        add(0,1,0, 1,3,0, 7,8,9, 0);
        add(0,0,1, 1,3,0, 7,8,10, 0);
        add(1,1,0, 0,0,0, 0,0,0, 0);
        add(1,1,0, 0,0,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0,0,0, 0);
        add(0,1,0, 0,0,0, 0,0,0, 0);
        add(0,0,0, 0,0,0, 0,0,0, 0);
        add(0,1,0, 1,1,0, 7,8,9, DC);
        add(0,0,0, 1,1,0, 7,8,9, 0);

        for (int idx = 0; idx < vecs.size(); idx++) begin
            vec_t v;
            vec_t e;
            v = vecs[idx];
            @(negedge clk);
            rst       = v.rst[0];
            btn_mode  = v.mode[0];
            btn_inc   = v.inc[0];
            cur_hours = 4'(v.ch);
            cur_mins  = 6'(v.cm);
            cur_secs  = 6'(v.cs);
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("setting",    idx, int'(setting),    e.e_set);
            chk("field",      idx, int'(field),      e.e_fld);
            chk("load",       idx, int'(load),       e.e_load);
            chk("load_hours", idx, int'(load_hours), e.e_h);
            chk("load_mins",  idx, int'(load_mins),  e.e_m);
            chk("load_secs",  idx, int'(load_secs),  e.e_s);
            chk("blink",      idx, int'(blink),      0);
            if (e.e_tick != DC) chk("tick_en", idx, int'(tick_en), e.e_tick);
            $display("vec %0d rst=%0d mode=%0d inc=%0d -> set=%0d fld=%0d load=%0d %0d:%0d:%0d tick=%0d",
                     idx, v.rst, v.mode, v.inc, setting, field, load,
                     load_hours, load_mins, load_secs, tick_en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
